// File: rtl/fsm_din_driver.sv
// Stimulus driver for the idle/s0/s1 din/dout toggle FSM: turns level requests into din pulse trains
// and checks the FSM against a cycle-accurate shadow model.
//   state | meaning
//   IDLE  | waiting for a request, din=0
//   PULSE | din=1 for n cycles
//   GAP   | din=0 for g cycles
//   DONE  | one-cycle completion pulse
module fsm_din_driver #(
  parameter int GAP_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_level,
  input  logic [GAP_W-1:0] req_gap,
  output logic             din,
  input  logic             fsm_dout,
  input  logic [1:0]       fsm_state,
  output logic             done,
  output logic             busy,
  output logic [1:0]       shadow_state,
  output logic             mismatch,
  output logic [CNT_W-1:0] mismatch_cnt,
  input  logic             err_clr
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} ctl_t;

  ctl_t             state, state_nxt;
  logic [1:0]       pcnt, pcnt_nxt;
  logic [GAP_W-1:0] gcnt, gcnt_nxt;
  logic             din_nxt;
  logic             accept;
  logic [1:0]       n_req;
  logic [GAP_W-1:0] g_req;
  logic             shadow_dout;
  logic             mis_now;

  // Pulses needed to reach the requested level from the modelled FSM state
  always_comb begin
    n_req = 2'd0;
    case (shadow_state)
      2'b00:   n_req = req_level ? 2'd2 : 2'd0;
      2'b01:   n_req = req_level ? 2'd1 : 2'd0;
      2'b10:   n_req = req_level ? 2'd0 : 2'd1;
      default: n_req = 2'd0;
    endcase
  end

  assign g_req  = (req_gap == '0) ? GAP_W'(1) : req_gap;
  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pcnt  <= 2'd0;
      gcnt  <= '0;
      din   <= 1'b0;
    end else begin
      state <= state_nxt;
      pcnt  <= pcnt_nxt;
      gcnt  <= gcnt_nxt;
      din   <= din_nxt;
    end
  end

  // Both counters are loaded at accept; gcnt is left alone until GAP
  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    gcnt_nxt  = gcnt;
    din_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          gcnt_nxt = g_req - GAP_W'(1);
          if (n_req != 2'd0) begin
            state_nxt = PULSE;
            pcnt_nxt  = n_req - 2'd1;
            din_nxt   = 1'b1;
          end else begin
            state_nxt = GAP;
          end
        end
      end
      PULSE: begin
        if (pcnt == 2'd0) begin
          state_nxt = GAP;
        end else begin
          pcnt_nxt = pcnt - 2'd1;
          din_nxt  = 1'b1;
        end
      end
      GAP: begin
        if (gcnt == '0) state_nxt = DONE;
        else            gcnt_nxt  = gcnt - GAP_W'(1);
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done      = (state == DONE);
    busy      = (state != IDLE);
    req_ready = (state == IDLE) && !rst;
  end

  // Shadow of the target FSM, advanced from the same registered din it sees
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_state <= 2'b00;
    end else if (din) begin
      case (shadow_state)
        2'b00:   shadow_state <= 2'b01;
        2'b01:   shadow_state <= 2'b10;
        2'b10:   shadow_state <= 2'b01;
        default: shadow_state <= 2'b00;
      endcase
    end
  end

  assign shadow_dout = (shadow_state == 2'b10);
  assign mis_now     = (fsm_state != shadow_state) || (fsm_dout != shadow_dout);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch     <= 1'b0;
      mismatch_cnt <= '0;
    end else if (err_clr) begin
      mismatch     <= mis_now;
      mismatch_cnt <= mis_now ? CNT_W'(1) : '0;
    end else if (mis_now) begin
      mismatch <= 1'b1;
      if (!(&mismatch_cnt)) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
    end
  end

endmodule
